// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the main FSM state enum, opcode/funct field values, the ALU
// operation class passed to the ALU decoder, and the 3-bit ALU control codes.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTEX,
        RTWB,
        BEQEX,
        ADDIEX,
        ADDIWB,
        JEX
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_controller_aludec.sv
// ALU decoder: maps the FSM's ALU operation class (and, for R-type,
// the funct field) to the 3-bit ALU control.
// Ports:
//   aluop      in  operation class from the main FSM
//   funct      in  instruction[5:0]
//   alucontrol out ALU operation code
//   badfunct   out high when aluop is FUNCT and funct is unsupported
module aludec
    import mips_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        badfunct
);

    always_comb begin
        alucontrol = ALU_ADD;
        badfunct   = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        // unsupported funct falls back to add so the
                        // datapath still sees a defined operation
                        alucontrol = ALU_ADD;
                        badfunct   = 1'b1;
                    end
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// Drives all datapath selects/enables and stalls on memready for
// every memory access.
// Ports:
//   clk, reset           clock, async active-high reset
//   op, funct, zero      IR fields and ALU zero flag
//   memready             memory access completes this cycle
//   pcen .. alucontrol   datapath controls
//   illegal              sticky unsupported-instruction flag
//
// state  | meaning
// -------+-------------------------------------------------
// FETCH  | read instruction at PC, PC <= PC+1 on memready
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | effective address A + imm
// MEMRD  | load read, wait for memready
// MEMWB  | write MDR to rt
// MEMWR  | store write, wait for memready
// RTEX   | R-type ALU op A funct B
// RTWB   | write ALUOut to rd
// BEQEX  | compare A - B, take branch target on zero
// ADDIEX | A + imm
// ADDIWB | write ALUOut to rt
// JEX    | load jump target into PC
module mips_controller
    import mips_pkg::*;
#(
    parameter int OPW = 6
)(
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           memready,
    output logic           pcen,
    output logic           memwrite,
    output logic           irwrite,
    output logic           iord,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic           alusra,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsource,
    output logic [2:0]     alucontrol,
    output logic           illegal
);

    state_t state, state_nxt;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;
    logic   badfunct;
    logic   badop;
    logic   mr;

    // memready is masked during reset so no fetch strobe leaks out
    assign mr = memready & ~reset;

    assign badop = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                     op == OP_BEQ || op == OP_ADDI || op == OP_J);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (mr) state_nxt = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) state_nxt = MEMADR;
                else if (op == OP_RTYPE)        state_nxt = RTEX;
                else if (op == OP_BEQ)          state_nxt = BEQEX;
                else if (op == OP_ADDI)         state_nxt = ADDIEX;
                else if (op == OP_J)            state_nxt = JEX;
                else                            state_nxt = FETCH;
            end
            MEMADR: state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mr) state_nxt = MEMWB;
            MEMWB:  state_nxt = FETCH;
            MEMWR:  if (mr) state_nxt = FETCH;
            RTEX:   state_nxt = RTWB;
            RTWB:   state_nxt = FETCH;
            BEQEX:  state_nxt = FETCH;
            ADDIEX: state_nxt = ADDIWB;
            ADDIWB: state_nxt = FETCH;
            JEX:    state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusra   = 1'b0;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        aluop    = ALUOP_ADD;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mr;
                pcwrite = mr;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusra  = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTEX: begin
                alusra = 1'b1;
                aluop  = ALUOP_FUNCT;
            end
            RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusra   = 1'b1;
                aluop    = ALUOP_SUB;
                pcsource = 2'b01;
                branch   = 1'b1;
            end
            ADDIEX: begin
                alusra  = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
            end
            default: ;
        endcase
    end

    // zero is combinational from the datapath, so pcen follows it in BEQEX
    assign pcen = pcwrite | (branch & zero);

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct[5:0]),
        .alucontrol (alucontrol),
        .badfunct   (badfunct)
    );

    // badfunct can only be high in RTEX, where aluop is FUNCT
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if ((state == DECODE && badop) || badfunct)
            illegal <= 1'b1;
    end

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller. Control outputs are packed into one
// 16-bit word and compared against hand-computed per-cycle values:
//   [15] pcen [14] memwrite [13] irwrite [12] iord [11] memtoreg
//   [10] regdst [9] regwrite [8] alusra [7:6] alusrcb [5:4] pcsource
//   [3:1] alucontrol [0] illegal
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen, memwrite, irwrite, iord, memtoreg, regdst, regwrite, alusra;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [15:0] ctrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_controller #(.OPW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alusra     (alusra),
        .alusrcb    (alusrcb),
        .pcsource   (pcsource),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    assign ctrl = {pcen, memwrite, irwrite, iord, memtoreg, regdst, regwrite,
                   alusra, alusrcb, pcsource, alucontrol, illegal};

    localparam logic [15:0] C_RST    = 16'h0044; // FETCH, memready masked/low
    localparam logic [15:0] C_FETCH  = 16'hA044;
    localparam logic [15:0] C_DECODE = 16'h00C4;
    localparam logic [15:0] C_MEMADR = 16'h0184;
    localparam logic [15:0] C_MEMRD  = 16'h1004;
    localparam logic [15:0] C_MEMWB  = 16'h0A04;
    localparam logic [15:0] C_MEMWR  = 16'h5004;
    localparam logic [15:0] C_RTSLT  = 16'h010E;
    localparam logic [15:0] C_RTBAD  = 16'h0104;
    localparam logic [15:0] C_RTWB   = 16'h0604;
    localparam logic [15:0] C_BEQZ1  = 16'h811C;
    localparam logic [15:0] C_BEQZ0  = 16'h011C;
    localparam logic [15:0] C_ADDIEX = 16'h0184;
    localparam logic [15:0] C_ADDIWB = 16'h0204;
    localparam logic [15:0] C_JEX    = 16'h8024;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        #1;
        total++;
        assert (ctrl === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, ctrl, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        op       = 6'b100011;
        funct    = 6'b000000;
        zero     = 1'b0;
        memready = 1'b1;
        #1;
        chk("reset_vals", C_RST);
        tick();
        chk("reset_hold", C_RST);
        tick();

        // LW: FETCH DECODE MEMADR MEMRD MEMWB
        reset = 1'b0;
        chk("lw_c1_fetch", C_FETCH);
        tick(); chk("lw_c2_decode", C_DECODE);
        tick(); chk("lw_c3_memadr", C_MEMADR);
        tick(); chk("lw_c4_memrd", C_MEMRD);
        tick(); chk("lw_c5_memwb", C_MEMWB);
        tick(); chk("lw_next_fetch", C_FETCH);

        // SW with 3 stall cycles in MEMWR
        op = 6'b101011;
        tick(); chk("sw_decode", C_DECODE);
        tick(); chk("sw_memadr", C_MEMADR);
        tick(); memready = 1'b0; chk("sw_wr1", C_MEMWR);
        tick(); chk("sw_wr2", C_MEMWR);
        tick(); chk("sw_wr3", C_MEMWR);
        tick(); memready = 1'b1; chk("sw_wr4", C_MEMWR);
        tick(); chk("sw_fetch", C_FETCH);

        // FETCH stall, then BEQ with zero toggled inside BEQEX
        op = 6'b000100;
        memready = 1'b0; chk("fetch_stall1", C_RST);
        tick(); chk("fetch_stall2", C_RST);
        memready = 1'b1; chk("fetch_go", C_FETCH);
        tick(); chk("beq_decode", C_DECODE);
        tick(); zero = 1'b1; chk("beq_zero1", C_BEQZ1);
        zero = 1'b0; chk("beq_zero0", C_BEQZ0);
        tick(); chk("beq_fetch", C_FETCH);

        // RTYPE slt, zero high must not leak into pcen
        op = 6'b000000; funct = 6'b101010; zero = 1'b1;
        tick(); chk("rt_decode", C_DECODE);
        tick(); chk("rt_slt_ex", C_RTSLT);
        tick(); chk("rt_wb", C_RTWB);
        tick(); chk("rt_fetch", C_FETCH);
        zero = 1'b0;

        // ADDI
        op = 6'b001000;
        tick(); chk("addi_decode", C_DECODE);
        tick(); chk("addi_ex", C_ADDIEX);
        tick(); chk("addi_wb", C_ADDIWB);
        tick(); chk("addi_fetch", C_FETCH);

        // J
        op = 6'b000010;
        tick(); chk("j_decode", C_DECODE);
        tick(); chk("j_jex", C_JEX);
        tick(); chk("j_fetch", C_FETCH);

        // illegal opcode: back to FETCH, illegal sticky
        op = 6'b111111;
        tick(); chk("ill_decode", C_DECODE);
        tick(); chk("ill_fetch", C_FETCH | 16'h0001);
        op = 6'b100011;
        tick(); chk("ill_sticky_dec", C_DECODE | 16'h0001);
        tick(); chk("ill_sticky_adr", C_MEMADR | 16'h0001);
        tick(); chk("ill_sticky_rd", C_MEMRD | 16'h0001);

        // reset mid-MEMRD: immediate FETCH values, illegal cleared
        reset = 1'b1;
        chk("rst_async", C_RST);
        tick(); chk("rst_held", C_RST);
        reset = 1'b0;
        chk("rst_release", C_FETCH);

        // bad funct: illegal rises leaving RTEX
        op = 6'b000000; funct = 6'b000111;
        tick(); chk("bf_decode", C_DECODE);
        tick(); chk("bf_rtex", C_RTBAD);
        tick(); chk("bf_rtwb", C_RTWB | 16'h0001);
        tick(); chk("bf_fetch", C_FETCH | 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the 32-bit MIPS datapath. A Moore main FSM sequences fetch, decode, execute, memory and writeback. A combinational ALU decoder derives the 3-bit ALU control. The block drives every select, enable and write strobe of the datapath, and waits on a memory-ready handshake for every memory access. It sits beside the datapath inside the processor top level and consumes `op`, `funct` and `zero`.

## Interface
- `OPW`, 6, opcode and funct field width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH and clears `illegal`.
- `op`  in  OPW  instruction[31:26] from the IR.
- `funct`  in  OPW  instruction[5:0] from the IR.
- `zero`  in  1  ALU zero flag, combinational from the datapath.
- `memready`  in  1  memory has completed the current read or write this cycle.
- `pcen`  out  1  PC register enable.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  IR load enable.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `memtoreg`  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- `regdst`  out  1  destination select: 0 = rt, 1 = rd.
- `regwrite`  out  1  register file write enable.
- `alusra`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = constant 1, 10 = immediate, 11 = immediate<<2.
- `pcsource`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = zero.
- `alucontrol`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  sticky; set when an unsupported opcode is decoded.

## Operation
- Supported opcodes:
  - LW 100011
  - SW 101011
  - RTYPE 000000
  - BEQ 000100
  - ADDI 001000
  - J 000010
- States and transitions:
  - FETCH: iord=0, alusra=0, alusrcb=01, aluop=ADD, pcsource=00. irwrite and pcwrite = `memready`. Go to DECODE when `memready`, else hold.
  - DECODE: alusra=0, alusrcb=11, aluop=ADD (branch target into ALUOut). Next state by opcode:
    - LW or SW → MEMADR
    - RTYPE → RTEX
    - BEQ → BEQEX
    - ADDI → ADDIEX
    - J → JEX
    - anything else → FETCH, and set `illegal`.
  - MEMADR: alusra=1, alusrcb=10, aluop=ADD. LW → MEMRD; SW → MEMWR.
  - MEMRD: iord=1. Hold until `memready`, then go to MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
  - MEMWR: iord=1, memwrite=1. Hold until `memready`, then go to FETCH. `memwrite` stays asserted throughout the hold.
  - RTEX: alusra=1, alusrcb=00, aluop=FUNCT. Go to RTWB.
  - RTWB: regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
  - BEQEX: alusra=1, alusrcb=00, aluop=SUB, pcsource=01, branch=1. Go to FETCH.
  - ADDIEX: alusra=1, alusrcb=10, aluop=ADD. Go to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
  - JEX: pcsource=10, pcwrite=1. Go to FETCH.
- Any output not listed for a state is 0.
- `pcen` = pcwrite | (branch & `zero`).
- ALU decoder:
  - aluop ADD → 010; SUB → 110.
  - aluop FUNCT by `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other funct → 010 and sets `illegal`.

## Timing
- Reset is asynchronous and takes effect immediately. While `reset` is high, outputs equal FETCH values with `memready` masked to 0: `pcen`=0, `irwrite`=0, alusrcb=01, alucontrol=010, all others 0, `illegal`=0.
- Cycle counts with `memready` tied high:
  - J 3, BEQ 3
  - SW 4, RTYPE 4, ADDI 4
  - LW 5
  - Each cycle `memready` is low in FETCH, MEMRD or MEMWR adds one cycle.
- All outputs except `pcen` and the ALU decoder result are functions of state, plus `memready` in FETCH.
- `pcen` in BEQEX follows `zero` combinationally in the same cycle.
- `illegal` is registered: it rises on the clock edge leaving DECODE (or RTEX for a bad funct). Only `reset` clears it.
- Reset asserted mid-instruction abandons the instruction. No write strobe is asserted after the reset edge.

## Structure
- Package `mips_pkg` holds:
  - `state_t` enum with the 12 states
  - opcode and funct localparams
  - `aluop_t` enum (ADD, SUB, FUNCT)
  - alucontrol encodings
- Sub-module `aludec`: combinational, inputs aluop and funct, outputs alucontrol and a bad-funct flag.
- The main FSM is in this module. The state register uses an async-reset always block. Next-state and output logic are combinational.

## Test plan
- Reset release with `memready`=1 and IR=0x8C010004 (LW) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1 and `memtoreg`=1 only in cycle 5. `pcen`=1 only in cycle 1.
- SW with `memready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 consecutive cycles, then FETCH. `regwrite` never asserted.
- BEQ with `zero`=1 → `pcen`=1 and pcsource=01 in BEQEX. Repeat with `zero`=0 → `pcen`=0 in BEQEX.
- RTYPE with funct 101010 → alucontrol=111 in RTEX. `regdst`=1 and `regwrite`=1 in RTWB.
- Opcode 111111 → DECODE returns to FETCH and `illegal`=1 the next cycle. `illegal` stays 1 until `reset`.
- Reset asserted during MEMRD → state is FETCH immediately. Outputs equal the reset values before the next edge.
